// File: rtl/jam_pkg.sv
// Shared types and constants for the Job Assignment Machine permutation path.
package jam_pkg;

    localparam int N_WORKERS = 8;
    localparam int IDX_W     = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EMIT,
        ST_FIND,
        ST_SWAP,
        ST_REV,
        ST_DONE
    } perm_state_t;

    // One job index per worker. Entry i is the job given to worker i.
    typedef logic [N_WORKERS-1:0][IDX_W-1:0] perm_t;

    // Identity assignment: worker i gets job i.
    function automatic perm_t identity_perm();
        perm_t r;
        for (int i = 0; i < N_WORKERS; i++) begin
            r[i] = IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/jam_pivot_find.sv
// Combinational pivot/successor search for the next lexicographic permutation.
// Only the first N entries of the array take part; the rest are padding.
module jam_pivot_find
    import jam_pkg::*;
#(
    parameter int N = N_WORKERS
) (
    input  perm_t             a,
    output logic              found,
    output logic [IDX_W-1:0]  p,
    output logic [IDX_W-1:0]  s
);

    // Pivot: highest i below N-1 with an ascending pair at (i, i+1).
    always_comb begin
        found = 1'b0;
        p     = '0;
        for (int i = 0; i < N - 1; i++) begin
            if (a[i] < a[i+1]) begin
                found = 1'b1;
                p     = IDX_W'(i);
            end
        end
    end

    // Successor: highest j past the pivot whose job exceeds the pivot's job.
    always_comb begin
        s = '0;
        for (int j = 0; j < N; j++) begin
            if ((j > int'(p)) && (a[j] > a[p])) begin
                s = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/jam_perm_seq.sv
// Permutation sequencer: walks all N! assignments in lexicographic order and
// hands each one to the cost datapath over a valid/ready handshake.
module jam_perm_seq
    import jam_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = 3,
    parameter int CW = 16
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            start,
    input  logic            perm_ready,
    output logic            perm_valid,
    output logic [N*IW-1:0] perm,
    output logic            perm_last,
    output logic [CW-1:0]   perm_idx,
    output logic            busy,
    output logic            done
);

    perm_state_t      state_q, state_d;
    perm_t            a_q, a_d;
    logic [IDX_W-1:0] p_q, p_d;
    logic [IDX_W-1:0] s_q, s_d;
    logic [IDX_W-1:0] lo_q, lo_d;
    logic [IDX_W-1:0] hi_q, hi_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             piv_found;
    logic [IDX_W-1:0] piv_p;
    logic [IDX_W-1:0] piv_s;
    logic             descending;

    jam_pivot_find #(
        .N (N)
    ) u_pivot (
        .a     (a_q),
        .found (piv_found),
        .p     (piv_p),
        .s     (piv_s)
    );

    // Next-state logic; every array update is a single two-entry exchange so
    // the register always holds a true permutation.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        p_d     = p_q;
        s_d     = s_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = identity_perm();
                    idx_d   = '0;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (perm_ready) begin
                    state_d = ST_FIND;
                end
            end
            ST_FIND: begin
                if (!piv_found) begin
                    state_d = ST_DONE;
                end else begin
                    p_d     = piv_p;
                    s_d     = piv_s;
                    idx_d   = idx_q + CW'(1);
                    state_d = ST_SWAP;
                end
            end
            ST_SWAP: begin
                a_d[p_q] = a_q[s_q];
                a_d[s_q] = a_q[p_q];
                lo_d     = p_q + IDX_W'(1);
                hi_d     = IDX_W'(N - 1);
                state_d  = (int'(p_q) < N - 2) ? ST_REV : ST_EMIT;
            end
            ST_REV: begin
                a_d[lo_q] = a_q[hi_q];
                a_d[hi_q] = a_q[lo_q];
                lo_d      = lo_q + IDX_W'(1);
                hi_d      = hi_q - IDX_W'(1);
                if ((hi_q - lo_q) <= IDX_W'(2)) begin
                    state_d = ST_EMIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        valid_d = (state_d == ST_EMIT);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // State, array, pointers and registered flags.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            a_q     <= identity_perm();
            p_q     <= '0;
            s_q     <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            p_q     <= p_d;
            s_q     <= s_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Final assignment is the one with every adjacent pair descending.
    always_comb begin
        descending = 1'b1;
        for (int i = 0; i < N - 1; i++) begin
            if (!(a_q[i] > a_q[i+1])) begin
                descending = 1'b0;
            end
        end
    end

    // Flatten the array onto the output bus, worker 0 in the low bits.
    always_comb begin
        perm = '0;
        for (int i = 0; i < N; i++) begin
            perm[IW*i +: IW] = a_q[i][IW-1:0];
        end
    end

    assign perm_valid = valid_q;
    assign perm_last  = valid_q & descending;
    assign perm_idx   = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_jam_perm_seq.sv
// Directed bench for the permutation sequencer: N=4 table walk with
// back-pressure and done/busy timing, N=8 latency and reset-during-REV.
module tb_jam_perm_seq;

    logic        clk = 1'b0;
    logic        rst4_n, start4, ready4;
    logic        valid4, last4, busy4, done4;
    logic [7:0]  perm4;
    logic [15:0] idx4;
    logic        rst8_n, start8, ready8;
    logic        valid8, last8, busy8, done8;
    logic [23:0] perm8;
    logic [15:0] idx8;

    int checks = 0;
    int errors = 0;
    int dup_bad4 = 0;
    int dup_bad8 = 0;
    int done_cnt4 = 0;

    typedef struct {
        logic [15:0] digits;
        logic        last;
        int          gap;
    } vec_t;

    vec_t vecs [24];

    always #5 clk = ~clk;

    jam_perm_seq #(.N(4), .IW(2), .CW(16)) u_dut4 (
        .CLK(clk), .RST_N(rst4_n), .start(start4), .perm_ready(ready4),
        .perm_valid(valid4), .perm(perm4), .perm_last(last4),
        .perm_idx(idx4), .busy(busy4), .done(done4)
    );

    jam_perm_seq #(.N(8), .IW(3), .CW(16)) u_dut8 (
        .CLK(clk), .RST_N(rst8_n), .start(start8), .perm_ready(ready8),
        .perm_valid(valid8), .perm(perm8), .perm_last(last8),
        .perm_idx(idx8), .busy(busy8), .done(done8)
    );

    // Every sampled assignment must be a permutation; count the ones that are not.
    always @(negedge clk) begin
        logic [3:0] m4;
        logic [7:0] m8;
        m4 = '0;
        m8 = '0;
        for (int i = 0; i < 4; i++) m4[perm4[2*i +: 2]] = 1'b1;
        for (int i = 0; i < 8; i++) m8[perm8[3*i +: 3]] = 1'b1;
        if (m4 != 4'hF) dup_bad4++;
        if (m8 != 8'hFF) dup_bad8++;
        if (done4) done_cnt4++;
    end

    // Hex digits written worker 0 first, packed to the DUT bus layout.
    function automatic logic [7:0] pack4(input logic [15:0] d);
        logic [7:0] r;
        for (int i = 0; i < 4; i++) r[2*i +: 2] = d[(3-i)*4 +: 2];
        return r;
    endfunction

    function automatic logic [23:0] pack8(input logic [31:0] d);
        logic [23:0] r;
        for (int i = 0; i < 8; i++) r[3*i +: 3] = d[(7-i)*4 +: 3];
        return r;
    endfunction

    // Worker 0 in the most significant position, so numeric order is lex order.
    function automatic logic [23:0] lexkey8(input logic [23:0] p);
        logic [23:0] r;
        for (int i = 0; i < 8; i++) r[(7-i)*3 +: 3] = p[3*i +: 3];
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input int which, input logic s, input logic r);
        if (which == 4) begin
            start4 = s;
            ready4 = r;
        end else begin
            start8 = s;
            ready8 = r;
        end
    endtask

    // Count negedges until the selected DUT shows valid, bounded by budget.
    task automatic wait_valid(input int which, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((which == 4) ? valid4 : valid8) && n < budget);
    endtask

    initial begin
        logic [15:0] d4 [24];
        int          n;
        logic        found;
        logic        have_prev;
        logic [23:0] prev_key;
        logic [15:0] prev_idx;
        int          order_bad;
        int          idx_bad;

        d4 = '{16'h0123, 16'h0132, 16'h0213, 16'h0231, 16'h0312, 16'h0321,
               16'h1023, 16'h1032, 16'h1203, 16'h1230, 16'h1302, 16'h1320,
               16'h2013, 16'h2031, 16'h2103, 16'h2130, 16'h2301, 16'h2310,
               16'h3012, 16'h3021, 16'h3102, 16'h3120, 16'h3201, 16'h3210};
        for (int k = 0; k < 24; k++) begin
            vecs[k].digits = d4[k];
            vecs[k].last   = (k == 23);
            vecs[k].gap    = (k == 0) ? 1 : (((k - 1) % 2 == 0) ? 3 : 4);
        end

        rst4_n = 1'b0;
        rst8_n = 1'b0;
        apply_stimulus(4, 1'b0, 1'b0);
        apply_stimulus(8, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_output("rst4_perm", 32'(perm4), 32'(pack4(16'h0123)));
        check_output("rst4_flags", {28'd0, valid4, last4, busy4, done4}, 32'd0);
        check_output("rst4_idx", 32'(idx4), 32'd0);
        check_output("rst8_perm", 32'(perm8), 32'(pack8(32'h01234567)));
        check_output("rst8_flags", {28'd0, valid8, last8, busy8, done8}, 32'd0);
        rst4_n = 1'b1;
        rst8_n = 1'b1;

        // Back-pressure on the first assignment, then abort with reset.
        @(negedge clk);
        apply_stimulus(4, 1'b1, 1'b0);
        wait_valid(4, 10, n);
        check_output("bp_start_gap", 32'(n), 32'd1);
        apply_stimulus(4, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) start4 = 1'b1;
            if (c == 3) start4 = 1'b0;
            @(negedge clk);
            check_output("bp_hold", {valid4, 7'd0, perm4, idx4}, {1'b1, 7'd0, pack4(16'h0123), 16'd0});
        end
        apply_stimulus(4, 1'b0, 1'b1);
        @(negedge clk);
        check_output("bp_find_valid", 32'(valid4), 32'd0);
        ready4 = 1'b0;
        @(negedge clk);
        check_output("bp_swap_valid", 32'(valid4), 32'd0);
        @(negedge clk);
        check_output("bp_next", {valid4, 7'd0, perm4, idx4}, {1'b1, 7'd0, pack4(16'h0132), 16'd1});
        #2 rst4_n = 1'b0;
        #1;
        check_output("async_rst4", {valid4, busy4, 6'd0, perm4, idx4}, {2'b00, 6'd0, pack4(16'h0123), 16'd0});
        @(negedge clk);
        rst4_n = 1'b1;

        // Full N=4 walk, start held high to show it is ignored while running.
        @(negedge clk);
        apply_stimulus(4, 1'b1, 1'b1);
        for (int k = 0; k < 24; k++) begin
            wait_valid(4, 10, n);
            check_output($sformatf("gap%0d", k), 32'(n), 32'(vecs[k].gap));
            check_output($sformatf("perm%0d", k), 32'(perm4), 32'(pack4(vecs[k].digits)));
            check_output($sformatf("idx%0d", k), 32'(idx4), 32'(k));
            check_output($sformatf("last%0d", k), 32'(last4), 32'(vecs[k].last));
            if (k == 23) start4 = 1'b0;
        end
        @(negedge clk);
        check_output("fin_find", {30'd0, busy4, done4}, {30'd0, 1'b1, 1'b0});
        @(negedge clk);
        check_output("fin_done", {30'd0, busy4, done4}, {30'd0, 1'b1, 1'b1});
        @(negedge clk);
        check_output("fin_idle", {30'd0, busy4, done4}, {30'd0, 1'b0, 1'b0});
        check_output("fin_perm_kept", 32'(perm4), 32'(pack4(16'h3210)));
        check_output("fin_last_gated", {30'd0, valid4, last4}, 32'd0);
        check_output("done_pulses", 32'(done_cnt4), 32'd1);

        // N=8 run up to 07654321, checking lex order and index stepping.
        @(negedge clk);
        apply_stimulus(8, 1'b1, 1'b1);
        @(negedge clk);
        start8    = 1'b0;
        n         = 1;
        found     = 1'b0;
        have_prev = 1'b0;
        prev_key  = '0;
        prev_idx  = '0;
        order_bad = 0;
        idx_bad   = 0;
        while (n < 30000 && !found) begin
            if (valid8) begin
                if (have_prev) begin
                    if (lexkey8(perm8) <= prev_key) order_bad++;
                    if (idx8 != prev_idx + 16'd1) idx_bad++;
                end else if (idx8 != 16'd0) begin
                    idx_bad++;
                end
                prev_key  = lexkey8(perm8);
                prev_idx  = idx8;
                have_prev = 1'b1;
                if (idx8 == 16'd5039) found = 1'b1;
            end
            if (!found) begin
                @(negedge clk);
                n++;
            end
        end
        check_output("reach_5039", 32'(found), 32'd1);
        check_output("lex_order", 32'(order_bad), 32'd0);
        check_output("idx_step", 32'(idx_bad), 32'd0);
        check_output("p8_07654321", 32'(perm8), 32'(pack8(32'h07654321)));
        check_output("p8_last_low", 32'(last8), 32'd0);
        wait_valid(8, 20, n);
        check_output("p8_lat5_gap", 32'(n), 32'd6);
        check_output("p8_10234567", 32'(perm8), 32'(pack8(32'h10234567)));
        check_output("p8_idx5040", 32'(idx8), 32'd5040);
        wait_valid(8, 20, n);
        check_output("p8_lat2_gap", 32'(n), 32'd3);
        check_output("p8_10234576", 32'(perm8), 32'(pack8(32'h10234576)));
        @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        check_output("p8_rev_mid", {valid8, busy8, 6'd0, perm8}, {2'b01, 6'd0, pack8(32'h10234675)});
        #1 rst8_n = 1'b0;
        #1;
        check_output("rst8_in_rev", {valid8, busy8, done8, 5'd0, perm8}, {3'b000, 5'd0, pack8(32'h01234567)});
        check_output("rst8_idx", 32'(idx8), 32'd0);
        @(negedge clk);
        rst8_n = 1'b1;
        @(negedge clk);
        apply_stimulus(8, 1'b1, 1'b0);
        wait_valid(8, 10, n);
        start8 = 1'b0;
        check_output("restart_gap", 32'(n), 32'd1);
        check_output("restart_perm", 32'(perm8), 32'(pack8(32'h01234567)));
        check_output("restart_idx", 32'(idx8), 32'd0);

        check_output("dup_free4", 32'(dup_bad4), 32'd0);
        check_output("dup_free8", 32'(dup_bad8), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jam_perm_seq.md
# jam_perm_seq

Permutation sequencer for the Job Assignment Machine cost datapath. It enumerates every worker-to-job assignment of N workers to N jobs in lexicographic order and hands each assignment to the cost-accumulation datapath over a valid/ready handshake. It is the block that sequences the W/J cost-fetch and sum logic inside JAM. It also tells the consumer which assignment is final and how many assignments have been issued.

## Interface
- `N`, default 8: number of workers/jobs; legal range 2..8.
- `IW`, default 3: index width, $clog2(N).
- `CW`, default 16: permutation counter width; must hold N! (8! = 40320).
- `CLK` input, 1: single clock; all state updates on the rising edge.
- `RST_N` input, 1: reset, asynchronous and active-low.
- `start` input, 1: begin enumeration; sampled only in IDLE.
- `perm_ready` input, 1: consumer accepts `perm` this cycle.
- `perm_valid` output, 1: `perm` holds a valid assignment.
- `perm` output, N*IW: `perm[IW*i +: IW]` is the job assigned to worker i.
- `perm_last` output, 1: the current `perm` is the final assignment (strictly descending).
- `perm_idx` output, CW: zero-based index of the current `perm`.
- `busy` output, 1: the block is not in IDLE.
- `done` output, 1: one-cycle pulse after the final assignment is accepted.

## Operation
- Reset values:
  - State is IDLE.
  - All flags are 0, and `perm_idx` is 0.
  - `perm` is the identity (`perm[i] = i`).
- States: IDLE, EMIT, FIND, SWAP, REV, DONE.
- IDLE:
  - When `start` is 1, load the identity, clear `perm_idx`, and go to EMIT.
  - Otherwise stay in IDLE.
- EMIT:
  - `perm_valid` is 1.
  - While `perm_ready` is 0, `perm`, `perm_idx` and `perm_last` hold stable.
  - On accept (`perm_valid && perm_ready`) go to FIND.
- FIND:
  - Compute the pivot p combinationally: the largest i < N-1 with `a[i] < a[i+1]`.
  - Compute the successor s combinationally: the largest j > p with `a[j] > a[p]`.
  - If no pivot exists, go to DONE.
  - Otherwise register p and s, increment `perm_idx`, and go to SWAP.
- SWAP:
  - Exchange `a[p]` and `a[s]`, then set lo = p+1 and hi = N-1.
  - If lo < hi, go to REV; otherwise go to EMIT.
- REV:
  - Exchange `a[lo]` and `a[hi]`, then lo++ and hi--.
  - When the updated lo >= hi, go to EMIT.
  - Exactly one exchange happens per cycle.
- DONE: `done` is 1 for one cycle, then the state returns to IDLE. `perm` keeps the final (descending) assignment.
- `perm_last` is combinational from the `perm` register: 1 exactly when every adjacent pair is descending. It is gated by `perm_valid`.
- `start` is ignored outside IDLE.
- `perm_ready` is ignored outside EMIT.
- `RST_N` low at any point returns the block immediately to the reset values. An enumeration interrupted this way is not resumed.
- `perm` is always a permutation of 0..N-1: no duplicates, including during the SWAP and REV cycles.
- `perm_idx` never wraps. Its maximum value is N!-1.

## Timing
- `start` sampled on edge t gives `perm_valid` = 1 after edge t+1.
- Accept on edge t gives FIND in the next cycle and SWAP in the cycle after that. `perm_valid` returns after edge t+2+floor((N-1-p)/2).
  - Example, identity to 0123457 6 (p = N-2): 2 cycles.
  - Example, 07654321 to 10234567 (p = 0, N = 8): 2+3 = 5 cycles.
- Final accept on edge t: FIND runs in cycle t..t+1, `done` is high for the cycle after edge t+1, and `busy` falls after edge t+2.
- `perm_valid` never drops without an accept.
- There are no combinational paths from `perm_ready` to any output.

## Structure
- Shared package `jam_pkg`:
  - Constants N_WORKERS = 8 and IDX_W = 3.
  - The state enum `perm_state_t`.
  - The typedef `perm_t` (array of N IDX_W-bit job indices).
  - A function returning the identity `perm_t`.
- One sub-module fits naturally: `jam_pivot_find`. It is combinational and takes a `perm_t`. It outputs the pivot found flag, p, and s, using two priority encoders. The top level holds the FSM, the array register, the lo/hi pointers, and `perm_idx`.

## Test plan
- N=4, `perm_ready` held at 1, pulse `start`:
  - The bench sees 24 distinct assignments in lexicographic order, starting at 0123 and ending at 3210.
  - `perm_idx` runs 0..23.
  - `perm_last` is 1 only on 3210.
  - `done` pulses once, and `busy` drops.
- N=8, `perm_ready` held at 1:
  - The bench sees 40320 accepts, with the final `perm_idx` = 40319.
  - Feeding the cost datapath with the pattern-2 cost table gives the golden MinCost/MatchCount.
- Back-pressure:
  - Hold `perm_ready` at 0 for 5 cycles on 0123 (N=4): `perm`, `perm_idx` and `perm_valid` stay stable.
  - After release, the next assignment 0132 appears 2 cycles after the accept.
- Latency check, N=8:
  - Accepting 07654321 gives 10234567 with `perm_valid` 5 cycles after the accept.
  - During SWAP and REV, `perm` is always duplicate-free (checked by assertion).
- Reset during REV (N=8): pulse `RST_N` low mid-run.
  - Outputs go immediately to the reset values.
  - A new `start` restarts at the identity with `perm_idx` = 0.
- `start` pulses while in EMIT or REV have no effect on the sequence.
